pixel_sequencer: RTL and testbench

Upstream stage of the GPU pixel-counter pipe (pipe 0). Per frame it walks every screen pixel in raster order and, within each pixel, every enabled layer. It emits one (x, y, layer) beat per cycle to the downstream pipe over a valid/ready handshake. It also drives the increment strobe and the active-low per-pixel clear consumed by the layer counter.

---
 rtl/pixel_sequencer.sv | 154 +++++++++++++++
 tb/tb_pixel_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sequencer.sv
// pixel_sequencer
//   Walks every pixel of a frame in raster order and, inside each pixel,
//   every enabled layer, emitting one (x, y, layer) beat per accepted
//   valid/ready handshake. Also drives the layer counter's increment strobe
//   and active-low per-pixel clear.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   reset        in   asynchronous active-low reset
//   frame_start  in   start request, honoured only in IDLE
//   abort        in   synchronous frame abort, honoured only in RUN
//   layer_max    in   [4:0] last enabled layer index, latched on start
//   out_ready    in   downstream accepts the current beat
//   out_valid    out  beat present on pixel_x / pixel_y / layer
//   pixel_x      out  [9:0] current column
//   pixel_y      out  [8:0] current line
//   layer        out  [4:0] current layer
//   last_layer   out  beat is the last layer of its pixel
//   last_pixel   out  beat is the final beat of the frame
//   layer_inc    out  accepted-beat strobe
//   layer_clr_n  out  low on acceptance of a last_layer beat
//   busy         out  high in RUN and DONE
//   frame_done   out  one-cycle pulse on normal frame completion
module pixel_sequencer #(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       abort,
  input  logic [4:0] layer_max,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic [4:0] layer,
  output logic       last_layer,
  output logic       last_pixel,
  output logic       layer_inc,
  output logic       layer_clr_n,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [4:0] layer_q, layer_d;
  logic [4:0] lmax_q, lmax_d;

  logic is_last_layer;
  logic is_last_pixel;
  logic accept;

  // Flags depend only on registered state, so out_valid never sees out_ready.
  assign is_last_layer = (layer_q == lmax_q);
  assign is_last_pixel = is_last_layer && (x_q == X_LAST) && (y_q == Y_LAST);
  assign accept        = (state_q == S_RUN) && out_ready;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      layer_q <= '0;
      lmax_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      layer_q <= layer_d;
      lmax_q  <= lmax_d;
    end
  end

  // Next-state logic
  // NOTE: every signal gets a hold/default value first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    layer_d = layer_q;
    lmax_d  = lmax_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          lmax_d  = layer_max;
          x_d     = '0;
          y_d     = '0;
          layer_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort beats a coincident accept: the beat still strobes layer_inc
        // combinationally, but the walk does not advance.
        if (abort) begin
          x_d     = '0;
          y_d     = '0;
          layer_d = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          if (is_last_pixel) begin
            x_d     = '0;
            y_d     = '0;
            layer_d = '0;
            state_d = S_DONE;
          end else if (!is_last_layer) begin
            layer_d = layer_q + 5'd1;
          end else begin
            layer_d = '0;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 9'd1;
            end else begin
              x_d = x_q + 10'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid   = (state_q == S_RUN);
    busy        = (state_q != S_IDLE);
    frame_done  = (state_q == S_DONE);
    pixel_x     = x_q;
    pixel_y     = y_q;
    layer       = layer_q;
    last_layer  = is_last_layer;
    last_pixel  = is_last_pixel;
    layer_inc   = accept;
    layer_clr_n = !(accept && is_last_layer);
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer on a 4x2 screen. Expected beats are
// derived from the beat index by a raster-order model inside stream().
module tb_pixel_sequencer;

  localparam int H = 4;
  localparam int V = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       abort;
  logic [4:0] layer_max;
  logic       out_ready;
  logic       out_valid;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic [4:0] layer;
  logic       last_layer;
  logic       last_pixel;
  logic       layer_inc;
  logic       layer_clr_n;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int incs;
  int clr_lows;

  pixel_sequencer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .abort       (abort),
    .layer_max   (layer_max),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .layer       (layer),
    .last_layer  (last_layer),
    .last_pixel  (last_pixel),
    .layer_inc   (layer_inc),
    .layer_clr_n (layer_clr_n),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [4:0] lm);
    layer_max   = lm;
    frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
  endtask

  // Walks one frame beat by beat. abort_at / poke_at are beat indices at
  // which abort or a stray frame_start plus a layer_max change are driven.
  task automatic stream(input int lm, input bit stall, input int abort_at,
                        input int poke_at, output int n_inc, output int n_clr);
    int total, l, p, ex, ey, stalls;
    bit acc;
    total = H * V * (lm + 1);
    n_inc = 0;
    n_clr = 0;
    for (int b = 0; b < total; b++) begin
      l      = b % (lm + 1);
      p      = b / (lm + 1);
      ex     = p % H;
      ey     = p / H;
      stalls = 0;
      acc    = 1'b0;
      while (!acc) begin
        out_ready   = (stall && stalls < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
        abort       = (b == abort_at) && out_ready;
        frame_start = (b == poke_at);
        if (b == poke_at) layer_max = 5'd7;
        #1;
        check("out_valid",   out_valid,   1);
        check("pixel_x",     pixel_x,     ex);
        check("pixel_y",     pixel_y,     ey);
        check("layer",       layer,       l);
        check("last_layer",  last_layer,  (l == lm));
        check("last_pixel",  last_pixel,  (b == total - 1));
        check("layer_inc",   layer_inc,   out_ready);
        check("layer_clr_n", layer_clr_n, !(out_ready && l == lm));
        check("frame_done",  frame_done,  0);
        check("busy",        busy,        1);
        acc = out_ready;
        if (!acc) stalls++;
        if (acc) n_inc++;
        if (!layer_clr_n) n_clr++;
        next_cycle();
        abort       = 1'b0;
        frame_start = 1'b0;
        if (acc && b == abort_at) return;
      end
    end
  endtask

  // Expects the DONE cycle, pokes frame_start into it and confirms no restart.
  task automatic check_done();
    check("done_pulse", frame_done, 1);
    check("done_valid", out_valid,  0);
    check("done_busy",  busy,       1);
    check("done_inc",   layer_inc,  0);
    frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    check("idle_busy",  busy,       0);
    check("idle_done",  frame_done, 0);
    check("idle_valid", out_valid,  0);
    next_cycle();
    check("no_queue_valid", out_valid, 0);
    check("no_queue_busy",  busy,      0);
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    abort       = 1'b0;
    layer_max   = 5'd0;
    out_ready   = 1'b0;
    #12;
    check("rst_valid", out_valid,   0);
    check("rst_busy",  busy,        0);
    check("rst_done",  frame_done,  0);
    check("rst_inc",   layer_inc,   0);
    check("rst_clr_n", layer_clr_n, 1);
    check("rst_x",     pixel_x,     0);
    check("rst_y",     pixel_y,     0);
    check("rst_layer", layer,       0);
    reset = 1'b1;
    next_cycle();
    check("idle_after_rst", out_valid, 0);

    // Full frame without stalls, three layers
    start_frame(5'd2);
    stream(2, 1'b0, -1, -1, incs, clr_lows);
    check("nostall_incs", incs, 24);
    check("nostall_clrs", clr_lows, 8);
    check_done();

    // Same frame under pseudo-random backpressure
    start_frame(5'd2);
    stream(2, 1'b1, -1, -1, incs, clr_lows);
    check("stall_incs", incs, 24);
    check("stall_clrs", clr_lows, 8);
    check_done();

    // Single layer
    start_frame(5'd0);
    stream(0, 1'b0, -1, -1, incs, clr_lows);
    check("l0_incs", incs, 8);
    check("l0_clrs", clr_lows, 8);
    check_done();

    // Maximum layers
    start_frame(5'd31);
    stream(31, 1'b0, -1, -1, incs, clr_lows);
    check("l31_incs", incs, 256);
    check("l31_clrs", clr_lows, 8);
    check_done();

    // Abort on beat 10 (index 9) while accepting
    start_frame(5'd2);
    stream(2, 1'b0, 9, -1, incs, clr_lows);
    check("abort_incs",  incs,       10);
    check("abort_valid", out_valid,  0);
    check("abort_busy",  busy,       0);
    check("abort_done",  frame_done, 0);
    check("abort_x",     pixel_x,    0);
    check("abort_y",     pixel_y,    0);
    check("abort_layer", layer,      0);
    next_cycle();
    check("abort_no_done", frame_done, 0);
    start_frame(5'd2);
    stream(2, 1'b0, -1, -1, incs, clr_lows);
    check("restart_incs", incs, 24);
    check_done();

    // Stray frame_start and layer_max change mid-frame
    start_frame(5'd2);
    stream(2, 1'b0, -1, 5, incs, clr_lows);
    check("poke_incs", incs, 24);
    check_done();

    // Asynchronous reset between edges
    start_frame(5'd2);
    out_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid,   0);
    check("arst_busy",  busy,        0);
    check("arst_x",     pixel_x,     0);
    check("arst_y",     pixel_y,     0);
    check("arst_layer", layer,       0);
    check("arst_inc",   layer_inc,   0);
    check("arst_clr_n", layer_clr_n, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    check("arst_idle_busy",  busy,       0);
    check("arst_idle_valid", out_valid,  0);
    check("arst_idle_done",  frame_done, 0);
    start_frame(5'd1);
    stream(1, 1'b0, -1, -1, incs, clr_lows);
    check("post_rst_incs", incs, 16);
    check_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
